// File: rtl/axi_lite_pkg.sv
// Shared types and response codes for the AXI4-Lite data-memory responder.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_ADDR, W_RESP} wr_state_t;
    typedef enum logic       {R_IDLE, R_DATA}                 rd_state_t;

    // {awready, wready} that a write state presents once any stall has elapsed.
    function automatic logic [1:0] wr_readys(wr_state_t s);
        case (s)
            W_IDLE:  return 2'b11;
            W_DATA:  return 2'b01;
            W_ADDR:  return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/axi_lite_datmem_slave_if.sv
// AXI4-Lite bus between the pipeline's data-memory master and the memory responder.
interface axi_lite_datmem_slave_if;

    logic [31:0] axi_awaddr;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [2:0]  axi_awprot;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;
    logic [31:0] axi_araddr;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [2:0]  axi_arprot;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid;
    logic        axi_rready;

    modport slave (
        input  axi_awaddr, axi_awvalid, axi_awprot,
        input  axi_wdata, axi_wstrb, axi_wvalid,
        input  axi_bready,
        input  axi_araddr, axi_arvalid, axi_arprot,
        input  axi_rready,
        output axi_awready, axi_wready,
        output axi_bresp, axi_bvalid,
        output axi_arready,
        output axi_rdata, axi_rresp, axi_rvalid
    );

    modport master (
        output axi_awaddr, axi_awvalid, axi_awprot,
        output axi_wdata, axi_wstrb, axi_wvalid,
        output axi_bready,
        output axi_araddr, axi_arvalid, axi_arprot,
        output axi_rready,
        input  axi_awready, axi_wready,
        input  axi_bresp, axi_bvalid,
        input  axi_arready,
        input  axi_rdata, axi_rresp, axi_rvalid
    );

endinterface

// File: rtl/datmem_ram.sv
// Word-addressed data memory: one byte-enabled write port, one registered read port (read-before-write).
module datmem_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [3:0]    wstrb,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic          rclr,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // NOTE: the array has no reset on purpose; contents survive rst and a reset loop would block RAM inference.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // NOTE: non-blocking assignment makes a same-edge read see the word as it was before the write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= rclr ? '0 : mem[raddr];
    end

endmodule

// File: rtl/axi_lite_datmem_slave.sv
// AXI4-Lite responder in front of the core's data memory; independent write and read channels.
// Define AXI_SLV_WAITSTATE_EN to stall each ready for WAIT_CYCLES cycles after entering a ready state.
module axi_lite_datmem_slave
    import axi_lite_pkg::*;
#(
    parameter int          MEM_DEPTH   = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 2
) (
    input logic                    clk,
    input logic                    rst,
    axi_lite_datmem_slave_if.slave bus
);

    localparam int          AW   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [32:0] SPAN = 33'(MEM_DEPTH) << 2;

    function automatic logic addr_ok(logic [31:0] a);
        return (a[1:0] == 2'b00) && (a >= BASE_ADDR) && ({1'b0, 32'(a - BASE_ADDR)} < SPAN);
    endfunction

    function automatic logic [AW-1:0] word_idx(logic [31:0] a);
        return AW'((a - BASE_ADDR) >> 2);
    endfunction

`ifdef AXI_SLV_WAITSTATE_EN
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    logic [CW-1:0] wr_wait, rd_wait;
`else
    logic unused_wait_cfg;
    assign unused_wait_cfg = (WAIT_CYCLES != 0);
`endif

    logic unused_prot;
    assign unused_prot = ^{bus.axi_awprot, bus.axi_arprot};

    wr_state_t   wr_state, wr_next;
    logic        awready, wready, bvalid;
    logic [1:0]  bresp;
    logic [31:0] wr_addr_q, wr_data_q;
    logic [3:0]  wr_strb_q;
    logic        aw_hs, w_hs, wr_commit, wr_ok;
    logic [31:0] cm_addr, cm_data;
    logic [3:0]  cm_strb;

    assign aw_hs = bus.axi_awvalid & awready;
    assign w_hs  = bus.axi_wvalid & wready;
    assign wr_ok = addr_ok(cm_addr);

    // Commit happens on whichever handshake completes the address/data pair.
    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        wr_next   = wr_state;
        wr_commit = 1'b0;
        cm_addr   = wr_addr_q;
        cm_data   = wr_data_q;
        cm_strb   = wr_strb_q;
        case (wr_state)
            W_IDLE: begin
                cm_addr   = bus.axi_awaddr;
                cm_data   = bus.axi_wdata;
                cm_strb   = bus.axi_wstrb;
                wr_commit = aw_hs & w_hs;
                if (wr_commit)  wr_next = W_RESP;
                else if (aw_hs) wr_next = W_DATA;
                else if (w_hs)  wr_next = W_ADDR;
            end
            W_DATA: begin
                cm_data   = bus.axi_wdata;
                cm_strb   = bus.axi_wstrb;
                wr_commit = w_hs;
                if (w_hs) wr_next = W_RESP;
            end
            W_ADDR: begin
                cm_addr   = bus.axi_awaddr;
                wr_commit = aw_hs;
                if (aw_hs) wr_next = W_RESP;
            end
            W_RESP: begin
                if (bus.axi_bready) wr_next = W_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state  <= W_IDLE;
            awready   <= 1'b0;
            wready    <= 1'b0;
            bvalid    <= 1'b0;
            bresp     <= RESP_OKAY;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_strb_q <= '0;
`ifdef AXI_SLV_WAITSTATE_EN
            wr_wait   <= CW'(WAIT_CYCLES);
`endif
        end else begin
            wr_state <= wr_next;
            bvalid   <= (wr_next == W_RESP);
            if (wr_commit) bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            if (wr_state == W_IDLE && aw_hs) wr_addr_q <= bus.axi_awaddr;
            if (wr_state == W_IDLE && w_hs) begin
                wr_data_q <= bus.axi_wdata;
                wr_strb_q <= bus.axi_wstrb;
            end
            if (wr_next != wr_state) begin
`ifdef AXI_SLV_WAITSTATE_EN
                if (WAIT_CYCLES == 0) begin
                    {awready, wready} <= wr_readys(wr_next);
                end else begin
                    {awready, wready} <= 2'b00;
                    wr_wait           <= CW'(WAIT_CYCLES - 1);
                end
`else
                {awready, wready} <= wr_readys(wr_next);
`endif
            end else begin
`ifdef AXI_SLV_WAITSTATE_EN
                if (wr_wait != '0) wr_wait <= wr_wait - 1'b1;
                else               {awready, wready} <= wr_readys(wr_state);
`else
                {awready, wready} <= wr_readys(wr_state);
`endif
            end
        end
    end

    rd_state_t   rd_state, rd_next;
    logic        arready, rvalid, ar_hs, rd_ok;
    logic [1:0]  rresp;
    logic [31:0] rd_data;

    assign ar_hs = bus.axi_arvalid & arready;
    assign rd_ok = addr_ok(bus.axi_araddr);

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            R_IDLE: if (ar_hs)          rd_next = R_DATA;
            R_DATA: if (bus.axi_rready) rd_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state <= R_IDLE;
            arready  <= 1'b0;
            rvalid   <= 1'b0;
            rresp    <= RESP_OKAY;
`ifdef AXI_SLV_WAITSTATE_EN
            rd_wait  <= CW'(WAIT_CYCLES);
`endif
        end else begin
            rd_state <= rd_next;
            rvalid   <= (rd_next == R_DATA);
            if (ar_hs) rresp <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            if (rd_next != rd_state) begin
`ifdef AXI_SLV_WAITSTATE_EN
                if (WAIT_CYCLES == 0) begin
                    arready <= (rd_next == R_IDLE);
                end else begin
                    arready <= 1'b0;
                    rd_wait <= CW'(WAIT_CYCLES - 1);
                end
`else
                arready <= (rd_next == R_IDLE);
`endif
            end else begin
`ifdef AXI_SLV_WAITSTATE_EN
                if (rd_wait != '0) rd_wait <= rd_wait - 1'b1;
                else               arready <= (rd_state == R_IDLE);
`else
                arready <= (rd_state == R_IDLE);
`endif
            end
        end
    end

    datmem_ram #(.DEPTH(MEM_DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_commit & wr_ok),
        .waddr (word_idx(cm_addr)),
        .wstrb (cm_strb),
        .wdata (cm_data),
        .re    (ar_hs),
        .rclr  (~rd_ok),
        .raddr (word_idx(bus.axi_araddr)),
        .rdata (rd_data)
    );

    assign bus.axi_awready = awready;
    assign bus.axi_wready  = wready;
    assign bus.axi_bvalid  = bvalid;
    assign bus.axi_bresp   = bresp;
    assign bus.axi_arready = arready;
    assign bus.axi_rvalid  = rvalid;
    assign bus.axi_rresp   = rresp;
    assign bus.axi_rdata   = rd_data;

endmodule
